// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes a latched byte as start, LSB-first data, optional parity, stop.
// Each bit lasts Prescale clocks; a request in the last stop cycle chains the next frame with no gap.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [5:0]            cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  pe_q, pe_n;
  logic                  pt_q, pt_n;
  logic [5:0]            pre_q, pre_n;
  logic                  tx_n, busy_n, done_n;
  logic                  wrap, par_bit, accept;

  // pre_q always holds the effective bit period, so a Prescale of 0 is stored as 1
  assign wrap    = (cnt == pre_q - 6'd1);
  assign par_bit = (^data_q) ^ pt_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    pe_n    = pe_q;
    pt_n    = pt_q;
    pre_n   = pre_q;
    accept  = 1'b0;

    case (state)
      IDLE: begin
        accept = Data_Valid;
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          cnt_n   = 6'd0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_n   = 6'd0;
          shreg_n = shreg >> 1;
          if (idx == IDX_LAST) state_n = pe_q ? PARITY : STOP;
          else                 idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      PARITY: begin
        if (wrap) begin
          state_n = STOP;
          cnt_n   = 6'd0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      STOP: begin
        if (wrap) begin
          state_n = IDLE;
          cnt_n   = 6'd0;
          accept  = Data_Valid;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 6'd0;
        idx_n   = '0;
      end
    endcase

    if (accept) begin
      state_n = START;
      cnt_n   = 6'd0;
      idx_n   = '0;
      shreg_n = P_DATA;
      data_n  = P_DATA;
      pe_n    = Par_En;
      pt_n    = Par_Typ;
      pre_n   = (Prescale == 6'd0) ? 6'd1 : Prescale;
    end
  end

  // Outputs are registered, so they are derived from the state being entered
  always_comb begin
    tx_n   = 1'b1;
    busy_n = 1'b1;
    done_n = 1'b0;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_bit;
      STOP: begin
        tx_n   = 1'b1;
        done_n = (cnt_n == pre_n - 6'd1);
      end
      default: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      idx        <= '0;
      shreg      <= '0;
      data_q     <= '0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      pre_q      <= 6'd1;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      data_q     <= data_n;
      pe_q       <= pe_n;
      pt_q       <= pt_n;
      pre_q      <= pre_n;
      TX_OUT     <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule
